hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 57 +++++
 rtl/hazard_stage_reg.sv | 30 +++
 rtl/hazard_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_unit_pkg
// Shared encodings and types for the pipeline hazard unit.
//   FWD_*        : ALU operand-select encodings driven on ForwardAE/ForwardBE
//   RESULT_LOAD  : decode-stage ResultSrc value that marks a load
//   PCSRC_*      : execute-stage PC redirect encodings
//   CNT_W        : width of the saturating stall/flush event counters
//   e_stage_t    : shadow copy of the ID/EX fields the hazard logic needs
//   mw_stage_t   : shadow copy of the EX/MEM and MEM/WB fields it needs
// ---------------------------------------------------------------------------
package hazard_unit_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic [1:0]       result_src;
    } e_stage_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             reg_write;
    } mw_stage_t;

    // Operand forwarding select. The MEM stage holds the younger producer,
    // so it wins over WB when both match. x0 is hard-wired zero and is never
    // forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input mw_stage_t        m,
        input mw_stage_t        w
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (m.reg_write && (m.rd != '0) && (m.rd == rs)) begin
            sel = FWD_MEM;
        end else if (w.reg_write && (w.rd != '0) && (w.rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// ---------------------------------------------------------------------------
// hazard_stage_reg
// Parameterised shadow pipeline register for the hazard unit.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, clears q to zero
//   clr : synchronous clear, loads zero (a bubble) on the next edge
//   d   : next-stage value
//   q   : registered value
// ---------------------------------------------------------------------------
module hazard_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Stall / flush / forwarding control for a 5-stage RISC-V style pipeline.
// The unit keeps its own shadow copies of the E, M and W stage fields it
// needs, fed from the decode-stage inputs, so it only sees D-stage signals.
//   clk                  : rising-edge clock shared with the datapath
//   rst                  : asynchronous active-low reset
//   Rs1D, Rs2D, RdD      : decode-stage register indices
//   RegWriteD            : decode-stage register-write enable
//   ResultSrcD           : decode-stage result select (01 = load)
//   PCSrcE               : execute-stage PC redirect (00 = PC+4)
//   StallF, StallD       : hold PC and IF/ID
//   FlushD, FlushE       : clear IF/ID and ID/EX
//   ForwardAE, ForwardBE : ALU operand select (00 RF, 01 WB, 10 MEM)
//   StallCount           : saturating count of stalled cycles
//   FlushCount           : saturating count of redirect cycles
// ---------------------------------------------------------------------------
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic [1:0]       PCSrcE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int E_W  = $bits(e_stage_t);
    localparam int MW_W = $bits(mw_stage_t);

    e_stage_t         e_next;
    logic [E_W-1:0]   e_q;
    e_stage_t         e_reg;

    // Index 0 is the M stage, index 1 the W stage.
    logic [MW_W-1:0]  mw_d [2];
    logic [MW_W-1:0]  mw_q [2];
    mw_stage_t        m_reg;
    mw_stage_t        w_reg;

    logic             lw_stall;
    logic             redirect;

    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] flush_count_reg;

    // ---------------- shadow pipeline ----------------
    assign e_next = '{rs1: Rs1D, rs2: Rs2D, rd: RdD,
                      reg_write: RegWriteD, result_src: ResultSrcD};

    // A flush of ID/EX is mirrored here so a squashed or stalled
    // instruction becomes a bubble in the shadow E stage too.
    hazard_stage_reg #(.W(E_W)) u_e_reg (
        .clk (clk),
        .rst (rst),
        .clr (FlushE),
        .d   (e_next),
        .q   (e_q)
    );
    assign e_reg = e_q;

    assign mw_d[0] = {e_reg.rd, e_reg.reg_write};
    assign mw_d[1] = mw_q[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mw
            hazard_stage_reg #(.W(MW_W)) u_mw_reg (
                .clk (clk),
                .rst (rst),
                .clr (1'b0),
                .d   (mw_d[gi]),
                .q   (mw_q[gi])
            );
        end
    endgenerate

    assign m_reg = mw_q[0];
    assign w_reg = mw_q[1];

    // ---------------- hazard detection ----------------
    assign lw_stall = (e_reg.result_src == RESULT_LOAD) && (e_reg.rd != '0) &&
                      ((e_reg.rd == Rs1D) || (e_reg.rd == Rs2D));
    assign redirect = (PCSrcE != PCSRC_PC4);

    // A taken redirect squashes the dependent instruction anyway, so the
    // stall is dropped and the PC is free to load the target.
    assign StallF = lw_stall && !redirect;
    assign StallD = lw_stall && !redirect;
    assign FlushD = redirect;
    assign FlushE = lw_stall || redirect;

    assign ForwardAE = fwd_sel(e_reg.rs1, m_reg, w_reg);
    assign ForwardBE = fwd_sel(e_reg.rs2, m_reg, w_reg);

    // ---------------- saturating event counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (StallD && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
            if (FlushD && (flush_count_reg != '1)) begin
                flush_count_reg <= flush_count_reg + CNT_W'(1);
            end
        end
    end

    assign StallCount = stall_count_reg;
    assign FlushCount = flush_count_reg;

endmodule
